// File: rtl/uart_16550_regs_pkg.sv
// Shared definitions for the 16550-style UART register block.
// Contents: LCR bit positions, word-length encoding, transmitter FSM state
// type, and helpers that decode the frame format from the low six LCR bits.
package uart_16550_regs_pkg;

    // LCR field positions
    localparam int unsigned LCR_WLS_LO = 0;  // word length select [1:0]
    localparam int unsigned LCR_WLS_HI = 1;
    localparam int unsigned LCR_STB    = 2;  // extra stop length
    localparam int unsigned LCR_PEN    = 3;  // parity enable
    localparam int unsigned LCR_EPS    = 4;  // even parity select
    localparam int unsigned LCR_STICK  = 5;  // stick parity
    localparam int unsigned LCR_BREAK  = 6;  // break control
    localparam int unsigned LCR_DLAB   = 7;  // divisor latch access

    typedef enum logic [1:0] {
        WLS_5 = 2'b00,
        WLS_6 = 2'b01,
        WLS_7 = 2'b10,
        WLS_8 = 2'b11
    } wls_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Tick counter value on the last tick of a 16-tick bit
    localparam logic [4:0] BIT_LAST_TICK = 5'd15;

    // Index of the last data bit (4..7) for the frame format in fmt[5:0]
    function automatic logic [2:0] last_bit_idx(input logic [5:0] fmt);
        return 3'd4 + {1'b0, fmt[LCR_WLS_HI:LCR_WLS_LO]};
    endfunction

    // Tick counter value on the last tick of the stop period (16/24/32 ticks)
    function automatic logic [4:0] stop_last_tick(input logic [5:0] fmt);
        if (!fmt[LCR_STB])
            return 5'd15;
        else if (wls_t'(fmt[LCR_WLS_HI:LCR_WLS_LO]) == WLS_5)
            return 5'd23;
        else
            return 5'd31;
    endfunction

    // Parity bit over the active data bits
    function automatic logic parity_bit(input logic [5:0] fmt, input logic [7:0] data);
        logic [7:0] mask;
        logic       x;
        case (wls_t'(fmt[LCR_WLS_HI:LCR_WLS_LO]))
            WLS_5:   mask = 8'h1F;
            WLS_6:   mask = 8'h3F;
            WLS_7:   mask = 8'h7F;
            default: mask = 8'hFF;
        endcase
        x = ^(data & mask);
        if (fmt[LCR_STICK])
            return ~fmt[LCR_EPS];
        else if (fmt[LCR_EPS])
            return x;
        else
            return ~x;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word fall-through read data.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push_i      - write wdata_i (ignored when full)
//   pop_i       - discard head entry (ignored when empty)
//   clr_i       - empty the FIFO in one cycle; overrides push/pop
//   wdata_i     - write data
//   rdata_o     - head entry, valid while not empty
//   full_o      - count equals DEPTH
//   empty_o     - count equals zero
//   count_o     - current occupancy
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     clr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr_i)
            mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_tx.sv
// 16550-style UART transmitter: TX FIFO plus serializer FSM.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   wr_en        - single-cycle THR push strobe
//   wr_data      - THR byte
//   lcr          - Line Control Register (format latched per frame, break live)
//   fifo_en      - FCR[0]; 0 restricts the FIFO to a 1-byte holding register
//   tx_fifo_clr  - FCR[2] clear strobe
//   baud_tick    - strobe at 16x the baud rate
//   tx_out       - serial line, idles high
//   tx_ready     - FIFO empty (LSR[5])
//   tsr_empty    - FIFO empty and shifter idle (LSR[6])
//   fifo_count   - current FIFO occupancy
module uart_tx
    import uart_16550_regs_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [7:0]                   wr_data,
    input  logic [7:0]                   lcr,
    input  logic                         fifo_en,
    input  logic                         tx_fifo_clr,
    input  logic                         baud_tick,
    output logic                         tx_out,
    output logic                         tx_ready,
    output logic                         tsr_empty,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

    logic       fifo_full, fifo_empty, fifo_push, fifo_pop, full_eff;
    logic [7:0] fifo_rdata;

    tx_state_t  state_q, state_d;
    logic [4:0] tick_q,  tick_d;
    logic [2:0] bit_q,   bit_d;
    logic [7:0] shift_q, shift_d;
    logic [5:0] fmt_q,   fmt_d;
    logic       par_q,   par_d;
    logic       tx_q,    tx_d;
    logic       load, can_load;

    // DLAB only steers register addressing elsewhere
    logic unused_dlab;
    assign unused_dlab = lcr[LCR_DLAB];

    assign full_eff  = fifo_en ? fifo_full : (fifo_count != '0);
    assign fifo_push = wr_en && !full_eff;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .clr_i   (tx_fifo_clr),
        .wdata_i (wr_data),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // A clear in the same cycle wins over starting a new frame
    assign can_load = baud_tick && !fifo_empty && !tx_fifo_clr;

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fmt_d    = fmt_q;
        par_d    = par_q;
        load     = 1'b0;
        fifo_pop = 1'b0;

        case (state_q)
            IDLE: begin
                if (can_load) load = 1'b1;
            end
            START: begin
                if (baud_tick) begin
                    if (tick_q == BIT_LAST_TICK) begin
                        tick_d  = '0;
                        state_d = DATA;
                    end else begin
                        tick_d = tick_q + 5'd1;
                    end
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (tick_q == BIT_LAST_TICK) begin
                        tick_d = '0;
                        if (bit_q == last_bit_idx(fmt_q)) begin
                            state_d = fmt_q[LCR_PEN] ? PARITY : STOP;
                        end else begin
                            bit_d   = bit_q + 3'd1;
                            shift_d = {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        tick_d = tick_q + 5'd1;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    if (tick_q == BIT_LAST_TICK) begin
                        tick_d  = '0;
                        state_d = STOP;
                    end else begin
                        tick_d = tick_q + 5'd1;
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (tick_q == stop_last_tick(fmt_q)) begin
                        // Chain straight into the next start bit so the stop
                        // period is exact even when frames run back to back
                        tick_d  = '0;
                        state_d = IDLE;
                        if (can_load) load = 1'b1;
                    end else begin
                        tick_d = tick_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tick_d  = '0;
            end
        endcase

        if (load) begin
            fifo_pop = 1'b1;
            state_d  = START;
            tick_d   = '0;
            bit_d    = '0;
            shift_d  = fifo_rdata;
            fmt_d    = lcr[5:0];
            par_d    = parity_bit(lcr[5:0], fifo_rdata);
        end

        // Line level follows the next state so it is registered glitch-free
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
        if (lcr[LCR_BREAK]) tx_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            fmt_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            fmt_q   <= fmt_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    assign tx_out    = tx_q;
    assign tx_ready  = fifo_empty;
    assign tsr_empty = fifo_empty && (state_q == IDLE);

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] lcr = 8'h03;
    logic       fifo_en = 1'b1;
    logic       tx_fifo_clr = 1'b0;
    logic       baud_tick = 1'b0;
    logic       tx_out, tx_ready, tsr_empty;
    logic [4:0] fifo_count;

    int total = 0;
    int bad   = 0;

    uart_tx #(.FIFO_DEPTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .lcr         (lcr),
        .fifo_en     (fifo_en),
        .tx_fifo_clr (tx_fifo_clr),
        .baud_tick   (baud_tick),
        .tx_out      (tx_out),
        .tx_ready    (tx_ready),
        .tsr_empty   (tsr_empty),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; returns just after a negedge
    task automatic push(input logic [7:0] d);
        wr_data = d;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Stays put if the line is already low (first cycle of a start bit)
    task automatic wait_start(input string tag);
        int n = 0;
        while (tx_out !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, " start seen"}, 32'(n < 3000), 32'd1);
    endtask

    // Assumes one baud_tick per clock: each bit spans 16 negedges,
    // sampled at the middle; the stop period is measured until the line
    // falls again or the transmitter reports idle.
    task automatic rx_frame(input string tag, input int nbits, input bit pen,
                            input logic [7:0] exp_data, input logic exp_par,
                            input int exp_stop);
        logic [7:0] d = 8'h00;
        int stop_n = 0;
        wait_start(tag);
        repeat (8) @(negedge clk);
        check({tag, " start bit"}, 32'(tx_out), 32'd0);
        for (int i = 0; i < nbits; i++) begin
            repeat (16) @(negedge clk);
            d[i] = tx_out;
        end
        check({tag, " data"}, 32'(d), 32'(exp_data));
        if (pen) begin
            repeat (16) @(negedge clk);
            check({tag, " parity"}, 32'(tx_out), 32'(exp_par));
        end
        repeat (8) @(negedge clk);
        while (tx_out === 1'b1 && tsr_empty !== 1'b1 && stop_n < 64) begin
            @(negedge clk);
            stop_n++;
        end
        check({tag, " stop len"}, 32'(stop_n), 32'(exp_stop));
    endtask

    task automatic idle_check(input string tag, input int cycles);
        int lows = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (tx_out !== 1'b1) lows++;
        end
        check({tag, " line idle"}, 32'(lows), 32'd0);
    endtask

    initial begin
        // Reset values
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst tx_out", 32'(tx_out), 32'd1);
        check("rst tx_ready", 32'(tx_ready), 32'd1);
        check("rst tsr_empty", 32'(tsr_empty), 32'd1);
        check("rst count", 32'(fifo_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 8N1, 0x55
        lcr = 8'h03;
        push(8'h55);
        check("55 count", 32'(fifo_count), 32'd1);
        check("55 tx_ready", 32'(tx_ready), 32'd0);
        check("55 tsr_empty", 32'(tsr_empty), 32'd0);
        check("55 idle line", 32'(tx_out), 32'd1);
        baud_tick = 1'b1;
        rx_frame("8N1 55", 8, 1'b0, 8'h55, 1'b0, 16);
        check("55 tsr_empty end", 32'(tsr_empty), 32'd1);

        // Parity variants; lcr changed mid-frame must be ignored
        lcr = 8'h1B;
        push(8'h07);
        wait_start("8E1");
        lcr = 8'h00;
        rx_frame("8E1", 8, 1'b1, 8'h07, 1'b1, 16);
        lcr = 8'h0B;
        push(8'h07);
        rx_frame("8O1", 8, 1'b1, 8'h07, 1'b0, 16);
        lcr = 8'h3B;
        push(8'h07);
        rx_frame("stick", 8, 1'b1, 8'h07, 1'b0, 16);

        // Stop lengths
        lcr = 8'h04;
        push(8'h15);
        rx_frame("5N2", 5, 1'b0, 8'h15, 1'b0, 24);
        lcr = 8'h07;
        push(8'hC3);
        rx_frame("8N2", 8, 1'b0, 8'hC3, 1'b0, 32);

        // Sparse ticks: one every third clock
        begin
            int low_n = 0;
            int first = -1;
            int span  = -1;
            lcr = 8'h03;
            baud_tick = 1'b0;
            push(8'hFF);
            for (int c = 0; c < 2000; c++) begin
                baud_tick = (c % 3 == 0);
                @(negedge clk);
                if (tx_out === 1'b0) begin
                    low_n++;
                    if (first < 0) first = c;
                end
                if (first >= 0 && tsr_empty === 1'b1) begin
                    span = c - first;
                    break;
                end
            end
            check("div3 start cycles", 32'(low_n), 32'd48);
            check("div3 frame cycles", 32'(span), 32'd480);
        end

        // FIFO full, overflow drop, back-to-back drain
        baud_tick = 1'b0;
        fifo_en = 1'b1;
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
        check("fill count", 32'(fifo_count), 32'd16);
        push(8'hEE);
        check("overflow count", 32'(fifo_count), 32'd16);
        check("full tx_ready", 32'(tx_ready), 32'd0);
        baud_tick = 1'b1;
        for (int k = 0; k < 16; k++) begin
            wait_start("drain");
            check("drain count", 32'(fifo_count), 32'(15 - k));
            check("drain tx_ready", 32'(tx_ready), 32'(k == 15));
            rx_frame("drain", 8, 1'b0, 8'(8'h10 + k), 1'b0, 16);
        end
        check("drain tsr_empty", 32'(tsr_empty), 32'd1);
        idle_check("after drain", 200);

        // Holding-register mode
        baud_tick = 1'b0;
        fifo_en = 1'b0;
        push(8'hA1);
        push(8'hB2);
        check("hold count", 32'(fifo_count), 32'd1);
        baud_tick = 1'b1;
        rx_frame("hold", 8, 1'b0, 8'hA1, 1'b0, 16);
        idle_check("hold", 200);
        check("hold count end", 32'(fifo_count), 32'd0);
        fifo_en = 1'b1;

        // Clear while idle
        baud_tick = 1'b0;
        push(8'h3C);
        push(8'h5A);
        push(8'h99);
        check("clr pre count", 32'(fifo_count), 32'd3);
        tx_fifo_clr = 1'b1;
        @(negedge clk);
        tx_fifo_clr = 1'b0;
        check("clr count", 32'(fifo_count), 32'd0);
        check("clr tx_ready", 32'(tx_ready), 32'd1);
        baud_tick = 1'b1;
        idle_check("clr idle", 100);

        // Clear while a frame is in the shifter: that frame completes
        baud_tick = 1'b0;
        push(8'h3C);
        push(8'h5A);
        baud_tick = 1'b1;
        wait_start("clr mid");
        check("clr mid count", 32'(fifo_count), 32'd1);
        tx_fifo_clr = 1'b1;
        fork
            rx_frame("clr mid", 8, 1'b0, 8'h3C, 1'b0, 16);
            begin
                @(negedge clk);
                tx_fifo_clr = 1'b0;
                check("clr mid count after", 32'(fifo_count), 32'd0);
            end
        join
        idle_check("clr mid", 200);

        // Break holds the line low while the byte is consumed
        begin
            int lows = 0;
            lcr = 8'h43;
            push(8'h81);
            repeat (200) begin
                @(negedge clk);
                if (tx_out === 1'b0) lows++;
            end
            check("break lows", 32'(lows), 32'd200);
            check("break tsr_empty", 32'(tsr_empty), 32'd1);
            check("break count", 32'(fifo_count), 32'd0);
            lcr = 8'h03;
            @(negedge clk);
            check("break release", 32'(tx_out), 32'd1);
        end

        // Reset in the middle of DATA
        baud_tick = 1'b0;
        push(8'h00);
        push(8'h00);
        baud_tick = 1'b1;
        wait_start("rst mid");
        repeat (40) @(negedge clk);
        check("rst mid data low", 32'(tx_out), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rst mid tx_out", 32'(tx_out), 32'd1);
        check("rst mid count", 32'(fifo_count), 32'd0);
        check("rst mid tsr_empty", 32'(tsr_empty), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        idle_check("rst mid", 300);
        check("rst mid count end", 32'(fifo_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, TX FIFO depth in bytes (power of 2, at least 2).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port wr_en  input  1  single-cycle push strobe for a THR write, from the AXI register interface.
REQ-005 SHALL have port wr_data  input  8  THR byte to push.
REQ-006 SHALL have port lcr  input  8  Line Control Register, using the fields defined in the shared package.
REQ-007 SHALL have port fifo_en  input  1  FCR[0]; 0 means the FIFO acts as a 1-byte holding register.
REQ-008 SHALL have port tx_fifo_clr  input  1  FCR[2] single-cycle clear strobe.
REQ-009 SHALL have port baud_tick  input  1  one-cycle strobe at 16x the baud rate.
REQ-010 SHALL have port tx_out  output  1  serial line; idles high.
REQ-011 SHALL have port tx_ready  output  1  THR/FIFO empty (LSR[5]); feeds the THR-empty interrupt.
REQ-012 SHALL have port tsr_empty  output  1  FIFO empty and shifter idle (LSR[6]).
REQ-013 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.

Function
REQ-014 SHALL push wr_data on wr_en when not full; a push when full (full meaning count=FIFO_DEPTH, or count=1 with fifo_en=0) SHALL be dropped and leave the contents unchanged.
REQ-015 SHALL, on a push and a pop in the same cycle, leave the count unchanged; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-016 SHALL, on tx_fifo_clr, empty the FIFO in one cycle; a frame already loaded in the shifter SHALL complete.
REQ-017 SHALL implement the FSM states IDLE, START, DATA, PARITY, STOP.
REQ-018 SHALL move IDLE -> START on a baud_tick while the FIFO is non-empty, popping the byte and latching lcr in that same cycle.
REQ-019 SHALL ignore lcr changes mid-frame.
REQ-020 SHALL make each bit period exactly 16 baud_ticks, counted by a 5-bit tick counter.
REQ-021 SHALL drive tx_out low from the cycle after the pop.
REQ-022 SHALL send START, then DATA, then PARITY (only if lcr[3]=1), then STOP, then return to IDLE.
REQ-023 SHALL take the word length from lcr[1:0]: 00=5, 01=6, 10=7, 11=8 bits, sent LSB first.
REQ-024 SHALL set the parity bit as follows: lcr[5]=1 gives ~lcr[4]; else lcr[4]=1 (even) gives XOR of the data bits; else its inverse.
REQ-025 SHALL set stop length as follows: lcr[2]=0 gives 16 ticks; lcr[2]=1 gives 24 ticks for 5-bit words and 32 ticks otherwise.
REQ-026 SHALL, when the FIFO is non-empty at the end of STOP, start the next frame on the next baud_tick with no extra idle bit.
REQ-027 SHALL force tx_out low while lcr[6] (break) is set; the FSM SHALL keep running, so bytes are consumed but not visible.
REQ-028 SHALL have tx_ready=1 exactly when count=0.
REQ-029 SHALL have tsr_empty=1 exactly when count=0 and the state is IDLE.
REQ-030 SHALL ignore clk cycles without baud_tick for the bit timing.

Reset
REQ-031 SHALL, while rst_n=0, asynchronously force: state IDLE, tx_out=1, pointers, count and tick counter all 0, tx_ready=1, tsr_empty=1.
REQ-032 SHALL, on reset asserted mid-frame, abort the frame and drop the FIFO contents; tx_out SHALL be high with no glitch low.

Structure
REQ-033 SHALL place the LCR field positions, word-length encoding and tx_state_t enum in uart_16550_regs_pkg.
REQ-034 SHALL implement the FIFO as sub-module sync_fifo (parameters WIDTH, DEPTH) with push, pop, clr, full, empty and count; the serializer FSM stays in uart_tx.

Verification
REQ-035 SHALL cover: lcr=0x03, push 0x55, continuous baud_tick -> tx_out shows 0,1,0,1,0,1,0,1,0,1 at 16 ticks per bit, then tsr_empty=1 after 160 ticks.
REQ-036 SHALL cover: lcr=0x1B (8E1), push 0x07 -> parity bit 1; lcr=0x0B (8O1) -> parity bit 0; lcr=0x3B (stick) -> parity 0.
REQ-037 SHALL cover: lcr=0x04 (5-bit, 2 stop) -> stop lasts 24 ticks; lcr=0x07 -> stop lasts 32 ticks.
REQ-038 SHALL cover: fifo_en=1, push 17 bytes with no ticks -> fifo_count=16, 17th byte dropped; drain -> exactly 16 back-to-back frames and tx_ready rises after the 16th pop.
REQ-039 SHALL cover: fifo_en=0, push 0xA1 then 0xB2 with no ticks -> only 0xA1 transmitted.
REQ-040 SHALL cover: rst_n pulsed low during the DATA state -> tx_out=1 within the same cycle, count=0, no further frame.
